// File: rtl/fb_scan_arbiter.sv
// Frame-buffer RAM arbiter: display scanout owns the RAM during the active area,
// a small write FIFO drains into it during blanking. FB_DOUBLE_BUFFER_EN adds a bank bit and swap handshake.
module fb_scan_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            pixel_clk,
  input  logic                            reset,
  input  logic                            active_in,
  input  logic                            vsync_in,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
`ifdef FB_DOUBLE_BUFFER_EN
  input  logic                            swap_req,
  output logic                            swap_done,
  output logic [ADDR_W:0]                 mem_addr,
`else
  output logic [ADDR_W-1:0]               mem_addr,
`endif
  output logic                            mem_we,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic [DATA_W-1:0]               mem_rdata,
  output logic [DATA_W-1:0]               pix_data,
  output logic                            pix_valid,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            err_drop
);

`ifdef FB_DOUBLE_BUFFER_EN
  localparam int MA_W = ADDR_W + 1;
`else
  localparam int MA_W = ADDR_W;
`endif
  localparam int PIX_N = H_ACTIVE * V_ACTIVE;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(PIX_N - 1);
  localparam logic [ADDR_W:0]   PIX_LIMIT = (ADDR_W + 1)'(PIX_N);
  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_BLANK_IDLE  = 2'd0,
    ST_SCAN        = 2'd1,
    ST_BLANK_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   scan_addr_q, scan_addr_d;
  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    count_q, count_d;
  logic                ready_q;
  logic                push_s, pop_s, fifo_empty_s, head_in_range_s;
  logic [MA_W-1:0]     scan_mem_addr_s, wr_mem_addr_s, mem_addr_s, hold_addr_q;
  logic                mem_we_s, err_drop_s, act_d1_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic                pix_valid_q;
  logic [DATA_W-1:0]   pix_data_q;

  assign fifo_empty_s    = (count_q == {LVL_W{1'b0}});
  assign head_in_range_s = ({1'b0, fifo_addr_q[rd_ptr_q]} < PIX_LIMIT);
  assign push_s          = wr_valid && ready_q;
  assign count_d         = count_q + LVL_W'(push_s) - LVL_W'(pop_s);
  // The previous cycle's arbitration result doubles as the scanout stage-1 register.
  assign act_d1_s        = (state_q == ST_SCAN);

`ifdef FB_DOUBLE_BUFFER_EN
  logic disp_bank_q, swap_pend_q, vsync_q, swap_done_q, swap_fire_s;

  assign scan_mem_addr_s = {disp_bank_q, scan_addr_q};
  assign wr_mem_addr_s   = {~disp_bank_q, fifo_addr_q[rd_ptr_q]};
  // Swap only with nothing queued, so every queued write lands in the bank it was aimed at.
  assign swap_fire_s     = vsync_q && !vsync_in && swap_pend_q && fifo_empty_s;
  assign swap_done       = swap_done_q;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      disp_bank_q <= 1'b0;
      swap_pend_q <= 1'b0;
      vsync_q     <= 1'b1;
      swap_done_q <= 1'b0;
    end else begin
      vsync_q     <= vsync_in;
      swap_done_q <= swap_fire_s;
      if (swap_fire_s) begin
        disp_bank_q <= ~disp_bank_q;
        swap_pend_q <= 1'b0;
      end else if (swap_req) begin
        swap_pend_q <= 1'b1;
      end else begin
        swap_pend_q <= swap_pend_q;
      end
    end
  end
`else
  assign scan_mem_addr_s = scan_addr_q;
  assign wr_mem_addr_s   = fifo_addr_q[rd_ptr_q];
`endif

  always_ff @(posedge pixel_clk) begin
    if (reset) state_q <= ST_BLANK_IDLE;
    else       state_q <= state_d;
  end

  // Scanout always wins the RAM; the FIFO only drains while blanking.
  always_comb begin
    state_d = ST_BLANK_IDLE;
    if (reset)              state_d = ST_BLANK_IDLE;
    else if (active_in)     state_d = ST_SCAN;
    else if (!fifo_empty_s) state_d = ST_BLANK_DRAIN;
    else                    state_d = ST_BLANK_IDLE;
  end

  always_comb begin
    mem_addr_s  = hold_addr_q;
    mem_we_s    = 1'b0;
    mem_wdata_s = {DATA_W{1'b0}};
    pop_s       = 1'b0;
    err_drop_s  = 1'b0;
    case (state_d)
      ST_SCAN: begin
        mem_addr_s = scan_mem_addr_s;
      end
      ST_BLANK_DRAIN: begin
        pop_s       = 1'b1;
        mem_addr_s  = wr_mem_addr_s;
        mem_wdata_s = fifo_data_q[rd_ptr_q];
        mem_we_s    = head_in_range_s;
        err_drop_s  = !head_in_range_s;
      end
      default: begin
        mem_addr_s = hold_addr_q;
      end
    endcase
  end

  // Scan position saturates at the last pixel until the next vsync.
  always_comb begin
    scan_addr_d = scan_addr_q;
    if (!vsync_in)                                 scan_addr_d = {ADDR_W{1'b0}};
    else if (active_in && scan_addr_q != PIX_LAST) scan_addr_d = scan_addr_q + ADDR_W'(1);
    else                                           scan_addr_d = scan_addr_q;
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      scan_addr_q <= {ADDR_W{1'b0}};
      hold_addr_q <= {MA_W{1'b0}};
    end else begin
      scan_addr_q <= scan_addr_d;
      hold_addr_q <= mem_addr_s;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (push_s) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {LVL_W{1'b0}};
      ready_q  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      ready_q <= (count_d != LVL_FULL);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      pix_valid_q <= 1'b0;
      pix_data_q  <= {DATA_W{1'b0}};
    end else begin
      pix_valid_q <= act_d1_s;
      pix_data_q  <= act_d1_s ? mem_rdata : {DATA_W{1'b0}};
    end
  end

  assign wr_ready   = ready_q;
  assign fifo_level = count_q;
  assign mem_addr   = mem_addr_s;
  assign mem_we     = mem_we_s;
  assign mem_wdata  = mem_wdata_s;
  assign err_drop   = err_drop_s;
  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;

endmodule

// File: doc/fb_scan_arbiter.md
Name: fb_scan_arbiter

Overview:
- Owns the single-port frame-buffer RAM behind the 640x480@60Hz sync generator. Shares the RAM between two users:
  - display scanout, which has absolute priority during the active area;
  - a drawing writer, which uses a valid/ready handshake and is buffered by a small write FIFO drained only during blanking.
- Sits between the sync generator (active/vsync inputs), the RAM, and the pixel output path.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- ADDR_W, 19, pixel address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- DATA_W, 12, pixel width (RGB444)
- FIFO_DEPTH, 4, write FIFO entries, power of 2, minimum 2

Ports:
- pixel_clk  in  1  pixel clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- active_in  in  1  active-area flag from the sync generator
- vsync_in  in  1  vertical sync, active-low
- wr_valid  in  1  writer request
- wr_ready  out  1  FIFO can accept a write
- wr_addr  in  ADDR_W  linear pixel address, y*H_ACTIVE+x
- wr_data  in  DATA_W  pixel value
- mem_addr  out  ADDR_W (+1 with macro)  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, 1-cycle synchronous read latency
- pix_data  out  DATA_W  scanout pixel
- pix_valid  out  1  pix_data valid
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- err_drop  out  1  one-cycle pulse when an out-of-range write is discarded

Behaviour:
- Reset values:
  - scan_addr=0, FIFO empty, fifo_level=0, wr_ready=1 (registered !full).
  - pix_valid=0, pix_data=0, err_drop=0, mem_we=0, state=BLANK_IDLE.
- Scan counter: scan_addr is cleared on any cycle with vsync_in=0. Otherwise it increments by 1 on each cycle with active_in=1. It never wraps within a frame; the maximum value is H_ACTIVE*V_ACTIVE-1.
- FSM, re-evaluated every cycle from registered state plus active_in:
  - SCAN: entered/held whenever active_in=1. mem_addr=scan_addr, mem_we=0. No FIFO pop.
  - BLANK_DRAIN: active_in=0 and FIFO non-empty. Pop the head entry.
    - In-range head: mem_addr=head.addr, mem_wdata=head.data, mem_we=1.
    - Head addr >= H_ACTIVE*V_ACTIVE: mem_we=0 and err_drop=1 for that cycle, but the entry is still popped.
  - BLANK_IDLE: active_in=0 and FIFO empty. mem_we=0; mem_addr holds its last value.
  - active_in rising while draining: SCAN takes the RAM in that same cycle and the pop is suppressed. No write is lost.
- mem_addr, mem_we and mem_wdata are combinational from registered state and active_in. No registered stage is added in front of the RAM.
- Push rule: push on wr_valid && wr_ready.
  - A push and a pop in the same cycle are both legal.
  - When full, wr_ready=0 even if a pop occurs that cycle; wr_ready rises the cycle after the pop.
  - wr_addr and wr_data are sampled only on push.
- Scanout pipeline: 2-cycle latency.
  - Stage 1 registers active_in, as act_d1.
  - Stage 2: pix_valid<=act_d1 and pix_data<=act_d1 ? mem_rdata : 0.
  - Each active cycle therefore yields exactly one valid pixel 2 cycles later.
- fifo_level equals entries stored after the edge, range 0..FIFO_DEPTH.
- Reset mid-frame: FIFO flushed, pending writes discarded, pipeline cleared. Scan restarts at 0 on the next vsync_in low.

Optional Feature:
- FB_DOUBLE_BUFFER_EN defined:
  - mem_addr gains an MSB bank bit. Scanout uses disp_bank; FIFO drains write !disp_bank.
  - Adds input swap_req (1 bit, level or pulse) and output swap_done (1 bit).
  - A swap_req is latched into a pending flag.
  - On the first cycle vsync_in goes 1->0 with the flag pending: disp_bank toggles, the flag clears, and swap_done pulses for 1 cycle.
  - The swap is deferred until the FIFO is empty; it then takes the next vsync falling edge.
  - disp_bank resets to 0.
- Not defined: single bank. No swap ports; mem_addr is ADDR_W bits.

Test Plan:
- Reset, then drive 640 active cycles after vsync low -> mem_addr 0..639, mem_we=0 throughout; pix_valid high for exactly 640 cycles starting 2 cycles after the first active cycle; pix_data equals mem_rdata of the prior cycle.
- During active_in=1, push 4 writes, then attempt a 5th -> wr_ready=0 after the 4th, fifo_level=4, no mem_we. active_in falls -> 4 consecutive mem_we cycles with the pushed addr/data in order; fifo_level 4->0.
- Push wr_addr=307200 (out of range) during blanking -> popped with mem_we=0, err_drop high for 1 cycle, fifo_level returns to 0.
- FIFO holds 3 entries, blanking drain starts, active_in rises after 1 write -> remaining 2 writes held; mem_addr=scan_addr on the rising cycle; the 2 writes complete in the next blanking interval.
- Assert reset with fifo_level=2 mid-line -> next cycle fifo_level=0, pix_valid=0, wr_ready=1, mem_we=0.
- With FB_DOUBLE_BUFFER_EN defined: swap_req mid-frame -> disp_bank toggles 0->1 and swap_done pulses on the next vsync falling edge; subsequent writes have mem_addr MSB=0 and scan reads have MSB=1.
